// File: rtl/error_log_writer.sv
// error_log_writer: pops error records from the FIFO and writes them into a circular memory log.
// Define ERROR_LOG_TIMESTAMP_EN to append a 64-bit cycle timestamp word after each record.
module error_log_writer #(
    parameter int AW = 32,
    parameter int DL = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          VALID,
    input  logic [63:0]   ECD,
    output logic          ERD,
    input  logic          ENA,
    input  logic [AW-1:0] LOG_BASE,
    input  logic [DL-1:0] LOG_RIDX,
    output logic [DL-1:0] WIDX,
    output logic          ACT,
    input  logic          NEXT,
    output logic [AW-1:0] ADDR,
    output logic [63:0]   DATA,
    output logic          IRQ,
    input  logic          IACK,
    output logic          OVF,
    input  logic          OVFCLR,
    output logic [15:0]   DROPCNT
);
`ifdef ERROR_LOG_TIMESTAMP_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif
    typedef enum logic [1:0] {IDLE, WRITE, TSWR} state_t;
    state_t state;
    logic [DL-1:0] free;
    logic room;
    // one slot is always left empty so a full ring is distinguishable from an empty one
    assign free = LOG_RIDX - WIDX - DL'(1);
    assign room = {1'b0, free} >= (DL+1)'(NEED);
    assign ERD = (state == IDLE) & ENA & VALID & ~RESET;
`ifdef ERROR_LOG_TIMESTAMP_EN
    logic [63:0] ts, ts_q;
    logic [AW-1:0] base_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ts <= '0;
            ts_q <= '0;
            base_q <= '0;
        end else begin
            ts <= ts + 64'd1;
            if (ERD && room) begin
                ts_q <= ts;
                base_q <= LOG_BASE;
            end
        end
    end
`endif
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            ACT <= 1'b0;
            ADDR <= '0;
            DATA <= '0;
            WIDX <= '0;
            IRQ <= 1'b0;
            OVF <= 1'b0;
            DROPCNT <= '0;
        end else begin
            // clears first so a coincident set below takes priority
            if (IACK) IRQ <= 1'b0;
            if (OVFCLR) OVF <= 1'b0;
            case (state)
                IDLE: if (ERD) begin
                    if (room) begin
                        DATA <= ECD;
                        ADDR <= LOG_BASE + AW'(WIDX);
                        ACT <= 1'b1;
                        state <= WRITE;
                    end else begin
                        OVF <= 1'b1;
                        DROPCNT <= (DROPCNT == 16'hFFFF) ? DROPCNT : DROPCNT + 16'd1;
                    end
                end
                WRITE: if (NEXT) begin
                    WIDX <= WIDX + DL'(1);
`ifdef ERROR_LOG_TIMESTAMP_EN
                    ADDR <= base_q + AW'(WIDX + DL'(1));
                    DATA <= ts_q;
                    state <= TSWR;
`else
                    IRQ <= 1'b1;
                    ACT <= 1'b0;
                    state <= IDLE;
`endif
                end
                TSWR: if (NEXT) begin
                    WIDX <= WIDX + DL'(1);
                    IRQ <= 1'b1;
                    ACT <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_error_log_writer.sv
// tb_error_log_writer: directed vector table, corner sequences and randomized run against a queue-based log model.
module tb_error_log_writer;
    localparam int AW = 32;
    localparam int DL = 3;
    localparam int RING = 8;
`ifdef ERROR_LOG_TIMESTAMP_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif
    logic CLK = 1'b0;
    logic RESET, VALID, ENA, NEXT, IACK, OVFCLR, ERD, ACT, IRQ, OVF;
    logic [63:0] ECD, DATA;
    logic [AW-1:0] LOG_BASE, ADDR;
    logic [DL-1:0] LOG_RIDX, WIDX;
    logic [15:0] DROPCNT;
    always #5 CLK = ~CLK;
    error_log_writer #(.AW(AW), .DL(DL)) dut (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .ECD(ECD), .ERD(ERD), .ENA(ENA),
        .LOG_BASE(LOG_BASE), .LOG_RIDX(LOG_RIDX), .WIDX(WIDX), .ACT(ACT), .NEXT(NEXT),
        .ADDR(ADDR), .DATA(DATA), .IRQ(IRQ), .IACK(IACK), .OVF(OVF), .OVFCLR(OVFCLR),
        .DROPCNT(DROPCNT)
    );
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } wr_t;
    wr_t q[$];
    int m_widx, m_drop;
    logic m_irq, m_ovf;
    logic [31:0] m_addr;
    logic [63:0] m_data, m_ts;
    typedef struct {
        logic v;
        logic [63:0] e;
        logic n;
        logic ia;
        logic xe;
        logic xa;
        logic [31:0] xad;
        logic [63:0] xd;
        logic [2:0] xw;
        logic xi;
    } vec_t;
    vec_t tbl[12];
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        m_widx = 0;
        m_drop = 0;
        m_irq = 1'b0;
        m_ovf = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ts = '0;
    endtask
    // inputs are set at the falling edge; check, advance the model, then move to the next falling edge
    task automatic tick();
        logic exp_erd, done, drop;
        int free;
        wr_t w;
        #1;
        exp_erd = (q.size() == 0) && ENA && VALID && !RESET;
        chk("erd", ERD, exp_erd);
        chk("act", ACT, q.size() != 0);
        chk("addr", ADDR, m_addr);
        chk("data", DATA, m_data);
        chk("widx", WIDX, 64'(m_widx));
        chk("irq", IRQ, m_irq);
        chk("ovf", OVF, m_ovf);
        chk("dropcnt", DROPCNT, 64'(m_drop));
        if (RESET) model_reset();
        else begin
            done = (q.size() != 0) && NEXT;
            drop = 1'b0;
            if (done) begin
                void'(q.pop_front());
                m_widx = (m_widx + 1) % RING;
            end
            m_irq = (done && q.size() == 0) ? 1'b1 : IACK ? 1'b0 : m_irq;
            if (exp_erd) begin
                free = (int'(LOG_RIDX) - m_widx - 1 + 2 * RING) % RING;
                if (free >= NEED) begin
                    w.a = LOG_BASE + 32'(m_widx);
                    w.d = ECD;
                    q.push_back(w);
                    if (NEED == 2) begin
                        w.a = LOG_BASE + 32'((m_widx + 1) % RING);
                        w.d = m_ts;
                        q.push_back(w);
                    end
                end else begin
                    drop = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_ovf = drop ? 1'b1 : OVFCLR ? 1'b0 : m_ovf;
            if (q.size() != 0) begin
                m_addr = q[0].a;
                m_data = q[0].d;
            end
            m_ts = m_ts + 64'd1;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask
    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        tick();
        RESET = 1'b0;
    endtask
    initial begin
        RESET = 1'b1; VALID = 1'b0; ENA = 1'b1; NEXT = 1'b1; IACK = 1'b0; OVFCLR = 1'b0;
        ECD = '0; LOG_BASE = 32'h1000; LOG_RIDX = '0;
        model_reset();
        @(negedge CLK);
        do_reset();
        chk("rst_act", ACT, 1'b0);
        chk("rst_widx", WIDX, 3'd0);
        tbl[0]  = '{1'b1, 64'hA100_0000_0000_0042, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    64'h0,                   3'd0, 1'b0};
        tbl[1]  = '{1'b0, 64'hA100_0000_0000_0042, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 64'hA100_0000_0000_0042, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 64'hA100_0000_0000_0042, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 64'hA100_0000_0000_0042, 3'd1, 1'b1};
        tbl[3]  = '{1'b0, 64'hA100_0000_0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 64'hA100_0000_0000_0042, 3'd1, 1'b0};
        tbl[4]  = '{1'b1, 64'hB200_0000_0000_0007, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 64'hA100_0000_0000_0042, 3'd1, 1'b0};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1'b1, 64'hB200_0000_0000_0007, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1001, 64'hB200_0000_0000_0007, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 64'hB200_0000_0000_0007, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1001, 64'hB200_0000_0000_0007, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 64'hB200_0000_0000_0007, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1001, 64'hB200_0000_0000_0007, 3'd2, 1'b1};
        for (int i = 0; i < 12; i++) begin
            VALID = tbl[i].v; ECD = tbl[i].e; NEXT = tbl[i].n; IACK = tbl[i].ia;
            #1;
            chk($sformatf("tbl%0d_erd", i), ERD, tbl[i].xe);
            chk($sformatf("tbl%0d_act", i), ACT, tbl[i].xa);
            chk($sformatf("tbl%0d_addr", i), ADDR, tbl[i].xad);
            chk($sformatf("tbl%0d_data", i), DATA, tbl[i].xd);
            chk($sformatf("tbl%0d_widx", i), WIDX, tbl[i].xw);
            chk($sformatf("tbl%0d_irq", i), IRQ, tbl[i].xi);
            tick();
        end
        IACK = 1'b0; NEXT = 1'b1; LOG_BASE = 32'h2000;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            VALID = 1'b1; ECD = 64'(k) + 64'hC000; LOG_RIDX = 3'(m_widx - 1);
            tick();
            VALID = 1'b0;
            #1;
            chk("wrap_act", ACT, 1'b1);
            chk("wrap_addr", ADDR, 32'h2000 + 32'(k % 8));
            tick();
        end
        chk("wrap_widx", WIDX, 3'd2);
        do_reset();
        LOG_RIDX = '0;
        for (int k = 0; k < 9; k++) begin
            VALID = 1'b1; ECD = 64'(k) + 64'hD000;
            tick();
            VALID = 1'b0;
            tick();
        end
        chk("full_widx", WIDX, 3'd7);
        chk("full_ovf", OVF, 1'b1);
        chk("full_drop", DROPCNT, 16'd2);
        OVFCLR = 1'b1;
        tick();
        OVFCLR = 1'b0;
        chk("ovfclr_ovf", OVF, 1'b0);
        chk("ovfclr_drop", DROPCNT, 16'd2);
        VALID = 1'b1; OVFCLR = 1'b1;
        tick();
        VALID = 1'b0; OVFCLR = 1'b0;
        chk("ovf_contention", OVF, 1'b1);
        chk("drop_contention", DROPCNT, 16'd3);
        LOG_RIDX = 3'd4; VALID = 1'b1; IACK = 1'b1;
        tick();
        VALID = 1'b0;
        chk("irq_acked", IRQ, 1'b0);
        tick();
        IACK = 1'b0;
        chk("irq_contention", IRQ, 1'b1);
        chk("widx_wrap", WIDX, 3'd0);
        VALID = 1'b1;
        tick();
        VALID = 1'b0;
        tick();
        VALID = 1'b1; NEXT = 1'b0;
        tick();
        VALID = 1'b0;
        tick();
        chk("midwr_act", ACT, 1'b1);
        chk("midwr_widx", WIDX, 3'(NEED));
        RESET = 1'b1;
        #1;
        chk("midrst_act", ACT, 1'b0);
        chk("midrst_widx", WIDX, 3'd0);
        model_reset();
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            RESET = ($urandom_range(0, 299) == 0);
            if (RESET) model_reset();
            VALID = ($urandom_range(0, 3) != 0);
            ENA = ($urandom_range(0, 7) != 0);
            NEXT = $urandom_range(0, 1) == 1;
            IACK = ($urandom_range(0, 3) == 0);
            OVFCLR = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) LOG_RIDX = 3'($urandom);
            if ($urandom_range(0, 15) == 0) LOG_BASE = $urandom;
            ECD = {$urandom, $urandom};
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
